// File: rtl/seg_display_scanner.sv
// Multi-digit seven-segment scanner: hex or decimal (double dabble) display,
// leading-zero blanking, PWM brightness and a valid/ready load port.
module seg_display_scanner #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000,
  parameter int SCAN_W   = 17,
  parameter int BRIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  dec_mode,
  input  logic                  blank_lz,
  input  logic [BRIGHT_W-1:0]   bright,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic [7:0]            segments,
  output logic [DIGITS-1:0]     an,
  output logic                  overflow
);

  localparam int DW    = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(DW + 1);
  localparam int PW    = SCAN_W + BRIGHT_W + 1;

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DW - 1);

  // 10^DIGITS always fits in DW bits because 10^D < 16^D.
  function automatic logic [DW-1:0] pow10_limit();
    logic [DW-1:0] r;
    r = DW'(1);
    for (int i = 0; i < DIGITS; i++) r = r * DW'(10);
    return r;
  endfunction

  localparam logic [DW-1:0] DEC_LIMIT = pow10_limit();

  // Active-low {dp,g,f,e,d,c,b,a} glyphs, dp off.
  function automatic logic [7:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction

  // One double-dabble iteration: add 3 to every BCD digit >= 5, then shift
  // the {bcd, bin} pair left by one bit.
  function automatic logic [2*DW-1:0] dabble_step(input logic [DW-1:0] bcd,
                                                  input logic [DW-1:0] bin);
    logic [DW-1:0] adj;
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj, bin} << 1;
  endfunction

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t              state_q, state_d;
  logic [DW-1:0]       disp_q, disp_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic                dash_q, dash_d;
  logic                ovf_q, ovf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]       bin_q, bin_d;
  logic [DW-1:0]       bcd_q, bcd_d;
  logic [DIGITS-1:0]   dppend_q, dppend_d;
  logic [SCAN_W-1:0]   presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BRIGHT_W-1:0] bright_q, bright_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic [2*DW-1:0]     step;
  logic [DW-1:0]       shifted;
  logic [7:0]          pat;
  logic [PW-1:0]       presc_scaled, on_limit;
  logic                on, blank;

  assign load_ready = (state_q == IDLE);
  assign segments   = seg_q;
  assign an         = an_q;
  assign overflow   = ovf_q;

  // Load handshake and sequential binary-to-BCD conversion.
  always_comb begin
    state_d  = state_q;
    disp_d   = disp_q;
    dp_d     = dp_q;
    dash_d   = dash_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    dppend_d = dppend_q;
    step     = dabble_step(bcd_q, bin_q);
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          if (!dec_mode) begin
            disp_d = data_in;
            dp_d   = dp_in;
            dash_d = 1'b0;
            ovf_d  = 1'b0;
          end else if (data_in >= DEC_LIMIT) begin
            disp_d = '0;
            dp_d   = '0;
            dash_d = 1'b1;
            ovf_d  = 1'b1;
          end else begin
            bin_d    = data_in;
            bcd_d    = '0;
            cnt_d    = '0;
            dppend_d = dp_in;
            state_d  = CONVERT;
          end
        end
      end
      CONVERT: begin
        bcd_d = step[2*DW-1:DW];
        bin_d = step[DW-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        // Old display stays visible until the final bit has been shifted in.
        if (cnt_q == CNT_LAST) begin
          disp_d  = step[2*DW-1:DW];
          dp_d    = dppend_q;
          dash_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Digit scan, PWM window, blanking and glyph selection for the next output.
  always_comb begin
    presc_d  = (presc_q == SCAN_LAST) ? '0 : presc_q + SCAN_W'(1);
    idx_d    = idx_q;
    if (presc_q == SCAN_LAST) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    // Brightness is frozen for the whole slot once taken at its first cycle.
    bright_d = (presc_q == '0) ? bright : bright_q;
    presc_scaled = PW'(presc_q) << BRIGHT_W;
    on_limit     = (PW'(bright_d) + PW'(1)) * PW'(SCAN_DIV);
    on           = (presc_scaled < on_limit);
    shifted = disp_q >> {idx_q, 2'b00};
    blank   = blank_lz && !dash_q && (idx_q != '0) && (shifted == '0);
    pat     = seg7(shifted[3:0]);
    if (dp_q[idx_q]) pat[7] = 1'b0;
    if (dash_q) pat = 8'hBF;
    seg_d = 8'hFF;
    an_d  = '1;
    if (on && !blank) begin
      seg_d       = pat;
      an_d[idx_q] = 1'b0;
    end
  end

  // Control, display and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      disp_q   <= '0;
      dp_q     <= '0;
      dash_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      presc_q  <= '0;
      idx_q    <= '0;
      bright_q <= '0;
      seg_q    <= 8'hFF;
      an_q     <= '1;
    end else begin
      state_q  <= state_d;
      disp_q   <= disp_d;
      dp_q     <= dp_d;
      dash_q   <= dash_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      bright_q <= bright_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  // Conversion working registers; always initialised on a decimal handshake.
  always_ff @(posedge clk) begin
    bin_q    <= bin_d;
    bcd_q    <= bcd_d;
    dppend_q <= dppend_d;
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Scoreboard bench for seg_display_scanner (DIGITS=4, SCAN_DIV=4, BRIGHT_W=2).
module tb_seg_display_scanner;

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        dec_mode;
  logic        blank_lz;
  logic [1:0]  bright;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  segments;
  logic [3:0]  an;
  logic        overflow;

  seg_display_scanner #(
    .DIGITS(4), .SCAN_DIV(4), .SCAN_W(3), .BRIGHT_W(2)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in),
    .dec_mode(dec_mode), .blank_lz(blank_lz), .bright(bright),
    .load_valid(load_valid), .load_ready(load_ready),
    .segments(segments), .an(an), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    logic       rdy;
    logic       ovf;
    int         tag;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Expected display: glyph per digit and whether the digit is blanked.
  logic [7:0] tbl_seg[4];
  bit         tbl_blank[4];
  bit         inres;
  logic       exp_rdy, exp_ovf;
  int         n, lat;

  task automatic cmp(input string name, input int tag, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s cyc%0d: got %0h, want %0h", name, tag, act, req);
    end
  endtask

  // Monitor: compare every pending expectation against the DUT outputs.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp("an", e.tag, int'(an), int'(e.an));
      cmp("segments", e.tag, int'(segments), int'(e.seg));
      cmp("load_ready", e.tag, int'(load_ready), int'(e.rdy));
      cmp("overflow", e.tag, int'(overflow), int'(e.ovf));
    end
  end

  task automatic set_tbl(input logic [31:0] segs, input logic [3:0] blanks);
    for (int i = 0; i < 4; i++) begin
      tbl_seg[i]   = segs[8*i +: 8];
      tbl_blank[i] = blanks[i];
    end
  endtask

  // Advance one edge and push the outputs expected after it.
  task automatic tick();
    exp_t e;
    int p, d;
    @(posedge clk);
    #1;
    e.an = 4'hF; e.seg = 8'hFF; e.rdy = 1'b1; e.ovf = 1'b0;
    if (!inres) begin
      n++;
      p = (n - 1) % 4;
      d = ((n - 1) / 4) % 4;
      if (p == 0) lat = int'(bright);
      // SCAN_DIV=4, BRIGHT_W=2: p*4 < (b+1)*4  <=>  p <= b
      if (p <= lat && !tbl_blank[d]) begin
        e.an  = ~(4'b0001 << d);
        e.seg = tbl_seg[d];
      end
      e.rdy = exp_rdy;
      e.ovf = exp_ovf;
    end
    e.tag = n;
    q.push_back(e);
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic hex_load(input logic [15:0] v, input logic [3:0] dp);
    load_valid = 1'b1; dec_mode = 1'b0; data_in = v; dp_in = dp;
    exp_ovf = 1'b0;
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; data_in = '0; dp_in = '0; dec_mode = 1'b0; blank_lz = 1'b0;
    bright = 2'd3; load_valid = 1'b0;
    inres = 1'b1; n = 0; lat = 0; exp_rdy = 1'b1; exp_ovf = 1'b0;
    set_tbl(32'hC0C0C0C0, 4'b0000);
    #1 rst = 1'b0;

    // Reset held with random inputs, then release.
    for (int i = 0; i < 4; i++) begin
      data_in = 16'($urandom); dp_in = 4'($urandom); dec_mode = 1'($urandom);
      blank_lz = 1'($urandom); bright = 2'($urandom); load_valid = 1'($urandom);
      tick();
    end
    rst = 1'b1; inres = 1'b0; n = 0;
    bright = 2'd3; load_valid = 1'b0; dec_mode = 1'b0; blank_lz = 1'b0;
    ticks(4);

    // Hex load with dp on digit 2.
    hex_load(16'h12AF, 4'b0100);
    set_tbl(32'hF9_24_88_8E, 4'b0000);
    ticks(16);

    // Decimal 1234: busy for 16 cycles, stray load_valid ignored.
    load_valid = 1'b1; dec_mode = 1'b1; data_in = 16'd1234; dp_in = 4'b0000;
    exp_rdy = 1'b0;
    tick();
    load_valid = 1'b0; dec_mode = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 5) begin load_valid = 1'b1; data_in = 16'hFFFF; dp_in = 4'hF; end
      if (i == 6) load_valid = 1'b0;
      if (i == 16) exp_rdy = 1'b1;
      tick();
    end
    set_tbl(32'hF9_A4_B0_99, 4'b0000);
    ticks(16);

    // Decimal out of range: dashes, never blanked, ready stays high.
    load_valid = 1'b1; dec_mode = 1'b1; data_in = 16'd10000; dp_in = 4'hF;
    exp_ovf = 1'b1;
    tick();
    load_valid = 1'b0; dec_mode = 1'b0; blank_lz = 1'b1;
    set_tbl(32'hBFBFBFBF, 4'b0000);
    ticks(16);
    hex_load(16'h0005, 4'b0000);
    blank_lz = 1'b0;
    set_tbl(32'hC0_C0_C0_92, 4'b0000);
    ticks(8);

    // Leading-zero blanking.
    hex_load(16'h0050, 4'b0000);
    blank_lz = 1'b1;
    set_tbl(32'hFF_FF_92_C0, 4'b1100);
    ticks(16);
    hex_load(16'h0000, 4'b0000);
    set_tbl(32'hFF_FF_FF_C0, 4'b1110);
    ticks(16);

    // Brightness levels and a mid-slot change.
    hex_load(16'h8888, 4'b0000);
    blank_lz = 1'b0;
    set_tbl(32'h80808080, 4'b0000);
    bright = 2'd0;
    ticks(16);
    bright = 2'd1;
    ticks(16);
    while ((n % 4) != 2) tick();
    bright = 2'd3;
    ticks(12);

    // Reset in the middle of a conversion discards it.
    load_valid = 1'b1; dec_mode = 1'b1; data_in = 16'd9999; dp_in = 4'b0000;
    exp_rdy = 1'b0;
    tick();
    load_valid = 1'b0; dec_mode = 1'b0;
    ticks(3);
    @(negedge clk);
    #1 rst = 1'b0;
    inres = 1'b1;
    ticks(2);
    rst = 1'b1; inres = 1'b0; n = 0;
    exp_rdy = 1'b1; exp_ovf = 1'b0;
    set_tbl(32'hC0C0C0C0, 4'b0000);
    ticks(8);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
